// File: rtl/membus_arbiter_pkg.sv
// Shared Membus arbiter types and widths.
package membus_arbiter_pkg;

  localparam int unsigned MEMBUS_DATA_WIDTH = 32;
  localparam int unsigned XLEN              = 32;

  // Upper bound on master channels an arbiter instance is expected to serve.
  localparam int unsigned MEMBUS_ARB_MAX_CH = 8;

  // Width of a channel index; at least one bit even for degenerate sizes.
  function automatic int unsigned arb_id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned MEMBUS_ARB_ID_WIDTH = arb_id_width(MEMBUS_ARB_MAX_CH);

  // Owner ID wide enough for the largest supported arbiter.
  typedef logic [MEMBUS_ARB_ID_WIDTH-1:0] membus_arb_id_t;

  // Request-hold lock state of the arbiter.
  typedef enum logic {
    ARB_UNLOCKED = 1'b0,
    ARB_LOCKED   = 1'b1
  } arb_state_t;

endpackage

// File: rtl/membus_arbiter_if.sv
// Membus request/response bundle for N parallel channels.
// The master modport drives requests, the slave modport answers them.
interface membus_arbiter_if
  import membus_arbiter_pkg::*;
#(
  parameter int unsigned N          = 1,
  parameter int unsigned DATA_WIDTH = MEMBUS_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = XLEN
);

  logic [N-1:0]                valid;
  logic [N-1:0]                ready;
  logic [N*ADDR_WIDTH-1:0]     addr;
  logic [N-1:0]                wen;
  logic [N*DATA_WIDTH-1:0]     wdata;
  logic [N*DATA_WIDTH/8-1:0]   wmask;
  logic [N-1:0]                rvalid;
  logic [N*DATA_WIDTH-1:0]     rdata;

  modport master (
    output valid, addr, wen, wdata, wmask,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, addr, wen, wdata, wmask,
    output ready, rvalid, rdata
  );

endinterface

// File: rtl/membus_arb_id_fifo.sv
// Owner-ID FIFO: records which channel issued each in-flight request so
// responses can be routed back in acceptance order.
module membus_arb_id_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;

  logic [WIDTH-1:0] mem [DEPTH];
  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic ptr_t bump(input ptr_t p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Push into a full FIFO is allowed only when a pop frees the slot.
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/membus_arbiter.sv
// N-channel to 1 Membus arbiter with request-hold lock and in-order
// response routing through an owner-ID FIFO.
// Build option: define MEMBUS_ARB_FIXED_PRIO_EN for fixed priority
// (lowest index wins) instead of round-robin.
module membus_arbiter
  import membus_arbiter_pkg::*;
#(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned DATA_WIDTH  = MEMBUS_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = XLEN,
  parameter int unsigned OUTSTANDING = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  membus_arbiter_if.slave    m,
  membus_arbiter_if.master   s
);

  localparam int unsigned ID_W   = arb_id_width(N_CH);
  localparam int unsigned MASK_W = DATA_WIDTH / 8;

  typedef logic [ID_W-1:0] id_t;

  arb_state_t state_q;
  arb_state_t state_d;
  id_t        grant_q;
  id_t        grant_q_d;
  id_t        arb_pick;
  id_t        grant;
  logic       req;
  logic       blocked;
  logic       s_valid_int;
  logic       accept;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;
  id_t        fifo_head;

`ifdef MEMBUS_ARB_FIXED_PRIO_EN
  // Fixed priority: scan from the top so the lowest requester wins.
  always_comb begin
    arb_pick = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (m.valid[N_CH-1-k]) arb_pick = id_t'(N_CH - 1 - k);
    end
  end
`else
  id_t  rr_ptr;
  id_t  idx;
  logic found;

  // Round-robin: first requester at or after rr_ptr, cyclically.
  always_comb begin
    arb_pick = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx = id_t'((32'(rr_ptr) + k) % N_CH);
      if (!found && m.valid[idx]) begin
        arb_pick = idx;
        found    = 1'b1;
      end
    end
  end

  // Advance the round-robin pointer past the channel just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (grant == id_t'(N_CH - 1)) ? '0 : grant + 1'b1;
    end
  end
`endif

  // Lock state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_UNLOCKED;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_q_d;
    end
  end

  // Grant selection, slave-side valid and lock transitions.
  // A response popping this cycle frees its slot, so a full FIFO does not
  // block a new request in that same cycle. rst_n gates s_valid so the
  // combinational request path is idle while reset is held.
  always_comb begin
    state_d     = state_q;
    grant_q_d   = grant_q;
    pop         = s.rvalid[0] & ~fifo_empty;
    blocked     = fifo_full & ~pop;
    grant       = (state_q == ARB_LOCKED) ? grant_q : arb_pick;
    req         = (state_q == ARB_LOCKED) ? m.valid[grant_q] : |m.valid;
    s_valid_int = rst_n & req & ~blocked;
    accept      = s_valid_int & s.ready[0];
    case (state_q)
      ARB_UNLOCKED: begin
        if (s_valid_int && !s.ready[0]) begin
          state_d   = ARB_LOCKED;
          grant_q_d = grant;
        end
      end
      ARB_LOCKED: begin
        if (accept) state_d = ARB_UNLOCKED;
      end
      default: state_d = ARB_UNLOCKED;
    endcase
  end

  // Request mux toward the slave.
  always_comb begin
    s.valid[0] = s_valid_int;
    s.addr     = m.addr[grant*ADDR_WIDTH +: ADDR_WIDTH];
    s.wen[0]   = m.wen[grant];
    s.wdata    = m.wdata[grant*DATA_WIDTH +: DATA_WIDTH];
    s.wmask    = m.wmask[grant*MASK_W +: MASK_W];
  end

  // Per-channel ready and response routing back to the owner.
  always_comb begin
    m.ready  = '0;
    m.rvalid = '0;
    if (accept) m.ready[grant]     = 1'b1;
    if (pop)    m.rvalid[fifo_head] = 1'b1;
    m.rdata  = {N_CH{s.rdata}};
  end

  membus_arb_id_fifo #(
    .DEPTH (OUTSTANDING),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (pop),
    .din   (grant),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

endmodule

// File: doc/membus_arbiter.md
Name: membus_arbiter

Overview:
- N-channel to 1 arbiter for the Membus protocol (valid/ready request, rvalid/rdata response); generalises the point-to-point bus to multiple masters, e.g. fetch, LSU and debug sharing one memory.
- Round-robin grant with a request-hold lock.
- Up to OUTSTANDING requests in flight to the slave; responses are routed back in order via an owner-ID FIFO.
- Sits between core-side masters and the memory/MMIO slave.

Parameters:
- N_CH, 2, number of master channels (≥2).
- DATA_WIDTH, MEMBUS_DATA_WIDTH, data width (multiple of 8).
- ADDR_WIDTH, XLEN, address width.
- OUTSTANDING, 2, maximum accepted-but-unanswered requests (power of 2, ≥1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- m_valid  in  N_CH  per-channel request valid
- m_ready  out  N_CH  per-channel request accepted
- m_addr  in  N_CH*ADDR_WIDTH  channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- m_wen  in  N_CH  write enable
- m_wdata  in  N_CH*DATA_WIDTH  write data
- m_wmask  in  N_CH*DATA_WIDTH/8  byte mask
- m_rvalid  out  N_CH  response valid, one-hot or zero
- m_rdata  out  N_CH*DATA_WIDTH  response data; each slice is a copy of s_rdata
- s_valid  out  1  slave request valid
- s_ready  in  1  slave accepts request
- s_addr/s_wen/s_wdata/s_wmask  out  ADDR_WIDTH/1/DATA_WIDTH/DATA_WIDTH/8  muxed request fields
- s_rvalid  in  1  slave response valid
- s_rdata  in  DATA_WIDTH  slave response data

Behaviour:
- Protocol: the slave returns exactly one s_rvalid pulse per accepted request (reads and writes), in acceptance order. Accept = s_valid & s_ready.
- Reset: m_ready=0, m_rvalid=0, s_valid=0, lock=0, rr_ptr=0, FIFO empty, count=0.
- States:
  - UNLOCKED (lock=0): when count<OUTSTANDING and any m_valid, grant = first requesting channel at or after rr_ptr, cyclically. s_valid=1 and s_* = fields of the grant channel, combinationally in the same cycle. If no s_ready, register lock=1 and grant_q=grant.
  - LOCKED: s_* driven from channel grant_q regardless of other requests, so the request seen by the slave stays stable. Unlock on accept.
- Masters must hold their fields stable while m_valid=1 and m_ready=0. Dropping m_valid while locked is illegal; the arbiter keeps the lock and drives s_valid=m_valid[grant_q].
- m_ready[i] = (i==grant) & s_ready & s_valid. Zero latency.
- On accept: push grant index into the owner FIFO (depth OUTSTANDING, width clog2(N_CH)); rr_ptr <= (grant+1) mod N_CH; lock <= 0.
- Full (count==OUTSTANDING): s_valid=0 and no grant; a lock is still held in that case.
- Response: on s_rvalid, m_rvalid[fifo_head]=1, combinational, zero latency; then pop.
  - s_rvalid with the FIFO empty is a protocol error: drop it, assert no m_rvalid.
- Same-cycle accept and response: push and pop both happen; count is unchanged. A response for a request accepted in that same cycle is not possible (the slave latency is ≥1).
- Counter and pointer arithmetic wraps modulo OUTSTANDING.
- Reset mid-transaction flushes the FIFO. Responses arriving after reset are dropped as above.

Optional Feature:
- Macro MEMBUS_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr is removed and the lock rule is unchanged.
- Undefined: round-robin as above.

Decomposition:
- Package eei: MEMBUS_DATA_WIDTH, XLEN (existing). Add MEMBUS_ARB_MAX_CH and a typedef for the owner ID width.
- Sub-module membus_arb_id_fifo: synchronous FIFO with push/pop/full/empty/head, async active-low reset.
- Grant logic stays inline.

Test Plan:
- N_CH=2, both masters raise valid on the same cycle, s_ready=1 every cycle, slave read latency 1 -> grants alternate ch0, ch1, ch0. Each m_rvalid goes to the requester, and the data echoes its address 0x100/0x200.
- Ch1 valid, s_ready=0 for 3 cycles, ch0 raises valid on cycle 1 -> s_addr stays 0x200 (ch1) through all 4 cycles; ch0 is granted next.
- OUTSTANDING=2, slave never asserts rvalid -> after 2 accepts s_valid=0. A single s_rvalid pulse -> the next request is accepted the same cycle.
- Write from ch1: wen=1, wmask=4'b0011, wdata=0xDEADBEEF -> s_* match exactly; the write response reaches m_rvalid[1] only.
- Stray s_rvalid with the FIFO empty -> all m_rvalid stay 0; count stays 0.
- rst_n low while 2 requests are outstanding -> all outputs 0 immediately; after release, ch0 is granted first.
